// File: rtl/acc_cpu_core.sv
// acc_cpu_core: parametrised accumulator CPU core.
// It integrates the control FSM, accumulator/flags, ALU, program/data memory,
// I/O registers and the boot-loader port.
// Each instruction is two words, [opcode][operand], and runs in 3 cycles:
// FETCH_OP, FETCH_OPND, EXEC.
//
// Ports:
//   clk_i              rising-edge clock
//   reset_i            synchronous reset, active-low
//   in_pins_i          IO_CHANNELS input channels, ch k = [k*DATA_WIDTH +: DATA_WIDTH]
//   out_pins_o         IO_CHANNELS registered output channels, same packing
//   bl_programm_i      boot-loader mode (core parked while high)
//   bl_data_i          boot-loader write data
//   bl_address_i       boot-loader write address
//   bl_write_en_mem_i  boot-loader memory write strobe
//   halted_o           high while halted
//   carry_o / zero_o   carry and zero flags
//   pc_o               program counter (debug)
//
// Optional feature: define CPU_SINGLE_STEP_EN to add the step_mode_i and step_i
// ports. With step_mode_i=1, a new instruction is fetched only in cycles where
// step_i=1.
module acc_cpu_core #(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned IO_CHANNELS = 2
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [IO_CHANNELS*DATA_WIDTH-1:0] in_pins_i,
  output logic [IO_CHANNELS*DATA_WIDTH-1:0] out_pins_o,
  input  logic                              bl_programm_i,
  input  logic [DATA_WIDTH-1:0]             bl_data_i,
  input  logic [ADDR_WIDTH-1:0]             bl_address_i,
  input  logic                              bl_write_en_mem_i,
  output logic                              halted_o,
  output logic                              carry_o,
  output logic                              zero_o,
  output logic [ADDR_WIDTH-1:0]             pc_o
`ifdef CPU_SINGLE_STEP_EN
  ,
  input  logic                              step_mode_i,
  input  logic                              step_i
`endif
);

  typedef enum logic [2:0] {
    S_FETCH_OP,
    S_FETCH_OPND,
    S_EXEC,
    S_HALT,
    S_PROG
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LDI = 4'h1, OP_LDA = 4'h2, OP_STA = 4'h3,
    OP_ADD  = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
    OP_XOR  = 4'h8, OP_IN  = 4'h9, OP_OUT = 4'hA, OP_JMP = 4'hB,
    OP_JC   = 4'hC, OP_JZ  = 4'hD, OP_ADDI = 4'hE, OP_HLT = 4'hF
  } opcode_t;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0] opnd;
  logic                  c;
  logic                  z;

  opcode_t               op;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] m;
  logic                  step_ok;

  assign op   = opcode_t'(ir[3:0]);
  assign addr = opnd[ADDR_WIDTH-1:0];
  assign m    = mem[addr];

`ifdef CPU_SINGLE_STEP_EN
  assign step_ok = !step_mode_i || step_i;
`else
  assign step_ok = 1'b1;
`endif

  assign pc_o     = pc;
  assign halted_o = (state == S_HALT);
  assign carry_o  = c;
  assign zero_o   = z;

  // Channel selection. Indices at or beyond IO_CHANNELS are flagged invalid.
  logic [DATA_WIDTH-1:0] in_sel;
  logic                  ch_valid;

  always_comb begin
    in_sel   = '0;
    ch_valid = 1'b0;
    for (int unsigned k = 0; k < IO_CHANNELS; k++) begin
      if (32'(opnd) == k) begin
        ch_valid = 1'b1;
        in_sel   = in_pins_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ALU and execute decode.
  logic [DATA_WIDTH:0]   sum_m;
  logic [DATA_WIDTH:0]   sum_i;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] a_next;
  logic                  c_next;
  logic                  z_next;
  logic                  wr_a;
  logic                  jump;
  logic                  st_we;
  logic                  out_we;

  assign sum_m = {1'b0, a} + {1'b0, m};
  assign sum_i = {1'b0, a} + {1'b0, opnd};
  // The top bit of the widened difference is the borrow (set when A < M).
  assign diff  = {1'b0, a} - {1'b0, m};

  always_comb begin
    a_next = a;
    c_next = c;
    wr_a   = 1'b0;
    jump   = 1'b0;
    st_we  = 1'b0;
    out_we = 1'b0;
    unique case (op)
      OP_NOP:  ;
      OP_LDI:  begin a_next = opnd; wr_a = 1'b1; end
      OP_LDA:  begin a_next = m; wr_a = 1'b1; end
      OP_STA:  st_we = 1'b1;
      OP_ADD:  begin {c_next, a_next} = sum_m; wr_a = 1'b1; end
      OP_SUB:  begin {c_next, a_next} = diff; wr_a = 1'b1; end
      OP_AND:  begin a_next = a & m; wr_a = 1'b1; end
      OP_OR:   begin a_next = a | m; wr_a = 1'b1; end
      OP_XOR:  begin a_next = a ^ m; wr_a = 1'b1; end
      OP_IN:   begin a_next = ch_valid ? in_sel : '0; wr_a = 1'b1; end
      OP_OUT:  out_we = ch_valid;
      OP_JMP:  jump = 1'b1;
      OP_JC:   jump = c;
      OP_JZ:   jump = z;
      OP_ADDI: begin {c_next, a_next} = sum_i; wr_a = 1'b1; end
      OP_HLT:  ;
    endcase
    z_next = wr_a ? (a_next == '0) : z;
  end

  // Control FSM.
  always_ff @(posedge clk_i) begin
    if (!reset_i) state <= S_FETCH_OP;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bl_programm_i) begin
      state_next = S_PROG;
    end else begin
      unique case (state)
        S_FETCH_OP:   if (step_ok) state_next = S_FETCH_OPND;
        S_FETCH_OPND: state_next = S_EXEC;
        S_EXEC:       state_next = (op == OP_HLT) ? S_HALT : S_FETCH_OP;
        S_HALT:       state_next = S_HALT;
        S_PROG:       state_next = S_FETCH_OP;
        default:      state_next = S_FETCH_OP;
      endcase
    end
  end

  // Datapath registers. The boot loader overrides execution, so an instruction
  // in flight is abandoned and leaves no writes behind.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      pc         <= '0;
      a          <= '0;
      ir         <= '0;
      opnd       <= '0;
      c          <= 1'b0;
      z          <= 1'b0;
      out_pins_o <= '0;
    end else if (bl_programm_i) begin
      pc         <= '0;
      a          <= '0;
      c          <= 1'b0;
      z          <= 1'b0;
      out_pins_o <= '0;
    end else begin
      unique case (state)
        S_FETCH_OP: begin
          if (step_ok) begin
            ir <= mem[pc];
            pc <= pc + ADDR_WIDTH'(1);
          end
        end
        S_FETCH_OPND: begin
          opnd <= mem[pc];
          pc   <= pc + ADDR_WIDTH'(1);
        end
        S_EXEC: begin
          a <= a_next;
          c <= c_next;
          z <= z_next;
          if (jump) pc <= addr;
          if (out_we) begin
            for (int unsigned k = 0; k < IO_CHANNELS; k++) begin
              if (32'(opnd) == k) out_pins_o[k*DATA_WIDTH +: DATA_WIDTH] <= a;
            end
          end
        end
        S_PROG:  pc <= '0;
        S_HALT:  ;
        default: ;
      endcase
    end
  end

  // Memory write port, shared by the boot loader and STA. It is never cleared,
  // and writes are suppressed in reset cycles.
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = a;
    if (reset_i) begin
      if (bl_programm_i) begin
        mem_we    = bl_write_en_mem_i;
        mem_waddr = bl_address_i;
        mem_wdata = bl_data_i;
      end else if (state == S_EXEC && st_we) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_acc_cpu_core.sv
// tb_acc_cpu_core: self-checking bench for acc_cpu_core (4-bit data, 4-bit
// address, 2 channels). An instruction-level reference model is checked
// against the visible outputs every cycle. It is backed by directed programs
// with hand-computed expectations and by randomized programs/boot-loader/reset
// traffic.
module tb_acc_cpu_core;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_pins;
  logic [7:0] out_pins;
  logic       bl;
  logic [3:0] bl_data;
  logic [3:0] bl_addr;
  logic       bl_we;
  logic       halted;
  logic       carry;
  logic       zero;
  logic [3:0] pc;

  always #5 clk = ~clk;

  acc_cpu_core #(
    .DATA_WIDTH (4),
    .ADDR_WIDTH (4),
    .IO_CHANNELS(2)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_n),
    .in_pins_i        (in_pins),
    .out_pins_o       (out_pins),
    .bl_programm_i    (bl),
    .bl_data_i        (bl_data),
    .bl_address_i     (bl_addr),
    .bl_write_en_mem_i(bl_we),
    .halted_o         (halted),
    .carry_o          (carry),
    .zero_o           (zero),
    .pc_o             (pc)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ISA interpreter that retires a whole instruction on
  // every third cycle.
  int m_mem [16];
  int m_pc, m_a, m_c, m_z, m_ir, m_op, m_ph, m_halt, m_prog;
  int m_out [2];

  always @(posedge clk) begin : model_upd
    int mv, t;
    if (!reset_n) begin
      m_pc = 0; m_a = 0; m_c = 0; m_z = 0; m_ir = 0; m_op = 0;
      m_out[0] = 0; m_out[1] = 0; m_ph = 0; m_halt = 0; m_prog = 0;
    end else if (bl) begin
      if (bl_we) m_mem[bl_addr] = int'(bl_data);
      m_pc = 0; m_a = 0; m_c = 0; m_z = 0; m_out[0] = 0; m_out[1] = 0;
      m_prog = 1; m_halt = 0; m_ph = 0;
    end else if (m_prog != 0) begin
      m_prog = 0; m_pc = 0; m_ph = 0;
    end else if (m_halt == 0) begin
      if (m_ph == 0) begin
        m_ir = m_mem[m_pc]; m_pc = (m_pc + 1) % 16; m_ph = 1;
      end else if (m_ph == 1) begin
        m_op = m_mem[m_pc]; m_pc = (m_pc + 1) % 16; m_ph = 2;
      end else begin
        m_ph = 0;
        mv = m_mem[m_op % 16];
        case (m_ir)
          1:  begin m_a = m_op; m_z = int'(m_a == 0); end
          2:  begin m_a = mv; m_z = int'(m_a == 0); end
          3:  m_mem[m_op % 16] = m_a;
          4:  begin t = m_a + mv; m_c = int'(t > 15); m_a = t % 16; m_z = int'(m_a == 0); end
          5:  begin m_c = int'(m_a < mv); m_a = (m_a + 16 - mv) % 16; m_z = int'(m_a == 0); end
          6:  begin m_a = m_a & mv; m_z = int'(m_a == 0); end
          7:  begin m_a = m_a | mv; m_z = int'(m_a == 0); end
          8:  begin m_a = m_a ^ mv; m_z = int'(m_a == 0); end
          9:  begin
                m_a = (m_op < 2) ? ((int'(in_pins) >> (4 * m_op)) & 15) : 0;
                m_z = int'(m_a == 0);
              end
          10: if (m_op < 2) m_out[m_op] = m_a;
          11: m_pc = m_op % 16;
          12: if (m_c != 0) m_pc = m_op % 16;
          13: if (m_z != 0) m_pc = m_op % 16;
          14: begin t = m_a + m_op; m_c = int'(t > 15); m_a = t % 16; m_z = int'(m_a == 0); end
          15: m_halt = 1;
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison, taken on the falling edge.
  always @(negedge clk) begin
    cmp("pc", int'(pc), m_pc);
    cmp("halted", int'(halted), m_halt);
    cmp("carry", int'(carry), m_c);
    cmp("zero", int'(zero), m_z);
    cmp("out", int'(out_pins), m_out[1] * 16 + m_out[0]);
  end

  // Inputs change 1 time unit after the falling edge, away from the active edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  logic [3:0] prog [16];

  task automatic load();
    bl = 1'b1; bl_we = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      bl_addr = 4'(i); bl_data = prog[i]; bl_we = 1'b1;
      tick();
    end
    bl_we = 1'b0; bl = 1'b0;
    tick();
  endtask

  initial begin
    int r, blleft;
    reset_n = 1'b0; bl = 1'b0; bl_we = 1'b0; bl_addr = '0; bl_data = '0; in_pins = '0;
    run(2);
    cmp("rst_pc", int'(pc), 0);
    cmp("rst_out", int'(out_pins), 0);
    cmp("rst_flags", int'({halted, carry, zero}), 0);
    reset_n = 1'b1;

    // Program LDI 5; OUT 1; HLT.
    prog = '{4'h1, 4'h5, 4'hA, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0,
             4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    load();
    run(8);
    cmp("t1_not_halted", int'(halted), 0);
    run(1);
    cmp("t1_out", int'(out_pins), 8'h50);
    cmp("t1_halted", int'(halted), 1);
    cmp("t1_pc", int'(pc), 6);

    // ADD carry, then JC.
    prog = '{4'h1, 4'h9, 4'h4, 4'h8, 4'hA, 4'h0, 4'hC, 4'hC,
             4'h8, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0};
    load();
    run(9);
    cmp("t2_out", int'(out_pins), 8'h01);
    cmp("t2_carry", int'(carry), 1);
    cmp("t2_zero", int'(zero), 0);
    run(3);
    cmp("t2_jc_pc", int'(pc), 12);
    run(3);
    cmp("t2_halted", int'(halted), 1);

    // SUB: zero result, then borrow.
    prog = '{4'h1, 4'h3, 4'h5, 4'hE, 4'hA, 4'h0, 4'h5, 4'hF,
             4'hA, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h3, 4'h1};
    load();
    run(6);
    cmp("t3_zero1", int'(zero), 1);
    cmp("t3_carry0", int'(carry), 0);
    run(6);
    cmp("t3_carry1", int'(carry), 1);
    cmp("t3_zero0", int'(zero), 0);
    run(3);
    cmp("t3_out", int'(out_pins), 8'hF0);

    // I/O channel range.
    in_pins = 8'hA6;
    prog = '{4'h9, 4'h1, 4'hA, 4'h0, 4'h9, 4'h3, 4'hA, 4'h2,
             4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    load();
    run(6);
    cmp("t4_in1", int'(out_pins), 8'h0A);
    run(3);
    cmp("t4_in3_zero", int'(zero), 1);
    run(3);
    cmp("t4_out2_nochange", int'(out_pins), 8'h0A);

    // PC wrap: JMP D puts the LDI opcode at 0xF and its operand at 0x0.
    prog = '{4'hB, 4'hD, 4'h0, 4'hA, 4'h0, 4'hF, 4'h0, 4'h0,
             4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    load();
    run(7);
    cmp("t5_wrap_pc0", int'(pc), 0);
    run(1);
    cmp("t5_wrap_pc1", int'(pc), 1);
    run(7);
    cmp("t5_out", int'(out_pins), 8'h0B);
    run(3);
    cmp("t5_halt_pc", int'(pc), 7);

    // Boot loader aborts STA in its EXEC cycle.
    prog = '{4'h1, 4'h5, 4'hA, 4'h1, 4'h3, 4'hE, 4'hF, 4'h0,
             4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0};
    load();
    run(8);
    cmp("t6_pre_out", int'(out_pins), 8'h50);
    bl = 1'b1; bl_we = 1'b0;
    tick();
    cmp("t6_abort_out", int'(out_pins), 0);
    cmp("t6_abort_pc", int'(pc), 0);
    prog[0] = 4'h2; prog[1] = 4'hE; prog[2] = 4'hA; prog[3] = 4'h0; prog[4] = 4'hF; prog[5] = 4'h0;
    for (int i = 0; i < 6; i++) begin
      bl_addr = 4'(i); bl_data = prog[i]; bl_we = 1'b1;
      tick();
    end
    bl_we = 1'b0; bl = 1'b0;
    tick();
    run(9);
    cmp("t6_no_sta_write", int'(out_pins), 8'h02);
    cmp("t6_halted", int'(halted), 1);
    // A boot-loader write coinciding with reset must be dropped.
    reset_n = 1'b0; bl = 1'b1; bl_we = 1'b1; bl_addr = 4'hE; bl_data = 4'h9;
    tick();
    cmp("t6_rst_out", int'(out_pins), 0);
    reset_n = 1'b1; bl = 1'b0; bl_we = 1'b0;
    run(9);
    cmp("t6_rst_mem_kept", int'(out_pins), 8'h02);

    // Randomized programs with boot-loader bursts, resets and ignored strobes.
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < 16; i++) prog[i] = 4'($urandom_range(0, 15));
      in_pins = 8'($urandom);
      blleft = 0;
      load();
      for (int cyc = 0; cyc < 60; cyc++) begin
        r = int'($urandom % 100);
        reset_n = 1'b1;
        bl_addr = 4'($urandom); bl_data = 4'($urandom);
        if (blleft > 0) begin
          bl = 1'b1; bl_we = 1'($urandom % 2); blleft--;
        end else if (r < 3) begin
          bl = 1'b1; bl_we = 1'b0; blleft = $urandom_range(0, 3);
        end else begin
          bl = 1'b0; bl_we = 1'($urandom % 2);
          if (r == 3) reset_n = 1'b0;
        end
        if (r > 90) in_pins = 8'($urandom);
        tick();
      end
      bl = 1'b0; bl_we = 1'b0; reset_n = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
